// File: rtl/dff_pipeline_if.sv
// Valid/ready bundle for dff_pipeline: producer side, consumer side
// and the occupancy count.
interface dff_pipeline_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int OW = $clog2(DEPTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [OW-1:0]    occupancy;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  occupancy
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output occupancy
   );
endinterface

// File: rtl/dff_pipeline.sv
// DEPTH-stage register pipeline with valid/ready flow control,
// bubble collapsing, synchronous clear and registered occupancy.
module dff_pipeline #(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input logic           clk,
   input logic           rst_n,
   input logic           clr,
   dff_pipeline_if.slave bus
);
   localparam int OW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] d     [DEPTH];
   logic [WIDTH-1:0] d_nxt [DEPTH];
   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] v_nxt;
   logic [DEPTH:0]   rdy;
   logic [OW-1:0]    occ;
   logic [OW-1:0]    occ_nxt;

   // Walk from the output back so each stage sees the one after it.
   always_comb begin
      logic r;
      r = bus.out_ready;
      rdy[DEPTH] = r;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         r = !v[i] | r;
         rdy[i] = r;
      end
   end

   always_comb begin
      v_nxt = v;
      d_nxt = d;
      if (rdy[0]) begin
         v_nxt[0] = bus.in_valid;
         if (bus.in_valid) d_nxt[0] = bus.in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (rdy[i]) begin
            v_nxt[i] = v[i-1];
            if (v[i-1]) d_nxt[i] = d[i-1];
         end
      end
   end

   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++)
         occ_nxt = occ_nxt + OW'(v_nxt[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v   <= '0;
         occ <= '0;
         for (int i = 0; i < DEPTH; i++) d[i] <= RST_VAL;
      end else if (clr) begin
         v   <= '0;
         occ <= '0;
         for (int i = 0; i < DEPTH; i++) d[i] <= RST_VAL;
      end else begin
         v   <= v_nxt;
         occ <= occ_nxt;
         for (int i = 0; i < DEPTH; i++) d[i] <= d_nxt[i];
      end
   end

   assign bus.in_ready  = rdy[0] & !clr;
   assign bus.out_valid = v[DEPTH-1];
   assign bus.out_data  = d[DEPTH-1];
   assign bus.occupancy = occ;
endmodule

// File: doc/dff_pipeline.md
# dff_pipeline

Parametrised register pipeline with valid/ready flow control. It generalises the single async-reset D flip-flop into DEPTH stages of WIDTH-bit registers with per-stage valid bits, bubble collapsing, synchronous clear and an occupancy count. It sits between a producer and a consumer as a retiming and latency-matching stage.

## Interface
- WIDTH, 8: data width in bits, ≥1
- DEPTH, 4: number of register stages, ≥1
- RST_VAL, 0: value loaded into every data register on reset or clear (WIDTH bits)

- clk  input  1  clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear; active high
- in_valid  input  1  producer has data on in_data
- in_ready  output  1  pipeline accepts in_data this cycle
- in_data  input  WIDTH  input word
- out_valid  output  1  last stage holds valid data
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  WIDTH  data register of the last stage
- occupancy  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- Each stage i (0..DEPTH-1) has a data register d[i] and a valid bit v[i]. Stage 0 is the input stage. Stage DEPTH-1 drives out_data and out_valid.
- Define ready[DEPTH] = out_ready and ready[i] = !v[i] | ready[i+1]. in_ready = ready[0] & !clr.
- Bubble collapsing: a stage that is empty, or whose contents move on this cycle, loads from the stage before it. Bubbles never block upstream data.
- On a clock edge with clr = 0, for every i with ready[i+1] = 1:
  - v[i+1] <= v[i]
  - d[i+1] <= d[i] if v[i] = 1; otherwise d[i+1] holds
- Stage 0 updates when ready[0] = 1:
  - v[0] <= in_valid
  - d[0] <= in_data if in_valid = 1
- A stage with ready[i+1] = 0 holds both v and d.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - No word is ever dropped or duplicated.
- While out_valid = 1 and out_ready = 0, out_data is stable.
- Data registers of invalid stages hold their last value; only valid stages are meaningful.
- clr = 1 at a rising edge:
  - All v <= 0 and all d <= RST_VAL.
  - in_ready = 0 during that cycle, so nothing is accepted.
  - An out_valid & out_ready handshake in that same cycle still counts as a delivered word.
- occupancy = popcount(v), registered: it is updated from the next-state valid bits on the same edge.
- DEPTH = 1 gives a single register stage with full throughput: in_ready = !v[0] | out_ready.

## Timing
- Reset (rst_n = 0, asynchronous, independent of clk):
  - All v = 0 and all d = RST_VAL immediately.
  - out_valid = 0, out_data = RST_VAL, occupancy = 0.
  - in_ready = 1 once rst_n = 1 and clr = 0.
- Reset asserted mid-stream discards all in-flight words with no partial updates. The first edge after release behaves as an empty pipeline.
- Latency through an empty pipeline: a word accepted at edge N is visible on out_data/out_valid after edge N+DEPTH-1. It is therefore accepted in the cycle after edge N+DEPTH-1.
- Throughput: one word per cycle when out_ready stays high.
- in_ready depends combinationally on out_ready through the ready chain. No other output is combinational.
- Full pipeline (occupancy = DEPTH) with out_ready = 0: in_ready = 0.
- Full pipeline with out_ready = 1: in_ready = 1. A simultaneous push and pop keeps occupancy = DEPTH.

## Test plan
- Reset: set WIDTH=8, DEPTH=4, RST_VAL=8'hA5 and pulse rst_n low between clock edges -> out_data=8'hA5, out_valid=0 and occupancy=0 change immediately, without waiting for an edge.
- Streaming: push 8'h01..8'h08 on consecutive cycles with out_ready=1 -> the first word appears 3 edges after acceptance, then one word per cycle, in order, and occupancy settles at 4.
- Backpressure: hold out_ready=0 and push 6 words -> exactly 4 are accepted, in_ready=0 after the 4th, out_data=8'h01 stays stable. Release out_ready -> all 4 words are drained in order and in_ready returns high with the first pop.
- Bubble collapse: push 8'h11, idle 2 cycles, push 8'h22 with out_ready=0 -> both words pack into stages 3 and 2, occupancy=2, in_ready stays 1.
- Clear: with a full pipeline, assert clr together with in_valid=1 -> in_ready=0 that cycle, after the edge occupancy=0, out_valid=0 and out_data=RST_VAL.
- Mid-stream reset: drop rst_n with 3 words in flight -> all are lost. Push 8'h55 after release -> it emerges after 3 edges as the only word.
